instr_adder_meas_ctrl: RTL and testbench

- Measurement sequencer for the instrumented adder inside wrapped_project.
- Latches adder operands and the chain select, clears the ring-oscillator counter, and waits a settle time.
- Then enables the ring for an exact window of wb_clk_i cycles, stops it, waits for the counter to drain, and captures the count.
- Driven from LA bits: start, abort and config come in on la1_data_in, and result/status go out on la1_data_out through the wrapper's buffered outputs.

---
 rtl/instr_adder_meas_pkg.sv | 22 ++
 rtl/instr_adder_meas_ctrl_timer.sv | 34 +++
 rtl/instr_adder_meas_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_instr_adder_meas_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/instr_adder_meas_pkg.sv
// Shared types and constants for the instrumented-adder measurement sequencer.
// Contents: FSM state enum, CLEAR phase length, default parameter widths.
package instr_adder_meas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        RUN,
        DRAIN,
        CAPTURE
    } meas_state_e;

    localparam int unsigned CLEAR_CYC     = 2;

    localparam int unsigned ADD_W_DEF     = 8;
    localparam int unsigned CNT_W_DEF     = 24;
    localparam int unsigned WIN_W_DEF     = 16;
    localparam int unsigned DRAIN_CYC_DEF = 4;
    localparam int unsigned ACC_LOG2_DEF  = 2;

endpackage

// File: rtl/instr_adder_meas_ctrl_timer.sv
// meas_timer: loadable down-counter shared by every timed phase of the
// measurement sequencer. Loading N makes zero_o rise N cycles later.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   load_i         load val_i this cycle (takes priority over decrement)
//   val_i          load value
//   zero_o         counter is at zero
module meas_timer
    import instr_adder_meas_pkg::*;
#(
    parameter int unsigned W = WIN_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/instr_adder_meas_ctrl.sv
// instr_adder_meas_ctrl: measurement sequencer for the instrumented adder.
// On a rising edge of start it latches operands and chain select, clears the
// ring counter, waits settle_cycles, enables the ring for window_cycles,
// waits DRAIN_CYC for the counter to drain and captures ring_count.
// Optional build macro MEAS_ACCUM_EN: repeat the measurement 2^ACC_LOG2 times
// and report the average of the counts.
// Ports:
//   wb_clk_i, wb_rst_ni        clock, asynchronous active-low reset
//   start, abort               LA control levels (start is edge-detected)
//   op_a, op_b, bypass_sel     operands / chain select, latched on request
//   window_cycles, settle_cycles  phase lengths, sampled on request
//   ring_count                 ring counter value from the adder
//   adder_a, adder_b, chain_bypass  latched adder configuration
//   ring_en, cnt_clear         ring enable / counter clear
//   busy, done, result         status and captured count
module instr_adder_meas_ctrl
    import instr_adder_meas_pkg::*;
#(
    parameter int unsigned ADD_W     = ADD_W_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned WIN_W     = WIN_W_DEF,
    parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF,
    parameter int unsigned ACC_LOG2  = ACC_LOG2_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             start,
    input  logic             abort,
    input  logic [ADD_W-1:0] op_a,
    input  logic [ADD_W-1:0] op_b,
    input  logic             bypass_sel,
    input  logic [WIN_W-1:0] window_cycles,
    input  logic [3:0]       settle_cycles,
    input  logic [CNT_W-1:0] ring_count,
    output logic [ADD_W-1:0] adder_a,
    output logic [ADD_W-1:0] adder_b,
    output logic             chain_bypass,
    output logic             ring_en,
    output logic             cnt_clear,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result
);

    meas_state_e      state_q, state_d;
    logic             start_q;
    logic             req;
    logic [3:0]       settle_q;
    logic [WIN_W-1:0] win_q;
    logic             tmr_load;
    logic [WIN_W-1:0] tmr_val;
    logic             tmr_zero;

    logic [ADD_W-1:0] adder_a_q, adder_b_q;
    logic             chain_bypass_q, ring_en_q, cnt_clear_q, busy_q, done_q;
    logic [CNT_W-1:0] result_q;

`ifdef MEAS_ACCUM_EN
    localparam int unsigned ACC_W = CNT_W + ACC_LOG2;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_sum;
    logic [ACC_LOG2-1:0] iter_q;
    assign acc_sum = acc_q + ACC_W'(ring_count);
`endif

    assign req = start & ~start_q;

    meas_timer #(.W(WIN_W)) u_timer (
        .clk_i  (wb_clk_i),
        .rst_ni (wb_rst_ni),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .zero_o (tmr_zero)
    );

    // Zero-length SETTLE or RUN phases are skipped by jumping past them and
    // loading the timer for the next phase that actually has a length.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE: begin
                if (req && !abort) begin
                    state_d  = CLEAR;
                    tmr_load = 1'b1;
                    tmr_val  = WIN_W'(CLEAR_CYC - 1);
                end
            end
            CLEAR, SETTLE: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (state_q == CLEAR && settle_q != '0) begin
                        state_d = SETTLE;
                        tmr_val = WIN_W'(settle_q) - WIN_W'(1);
                    end else if (win_q != '0) begin
                        state_d = RUN;
                        tmr_val = win_q - WIN_W'(1);
                    end else begin
                        state_d = DRAIN;
                        tmr_val = WIN_W'(DRAIN_CYC - 1);
                    end
                end
            end
            RUN: begin
                if (tmr_zero) begin
                    state_d  = DRAIN;
                    tmr_load = 1'b1;
                    tmr_val  = WIN_W'(DRAIN_CYC - 1);
                end
            end
            DRAIN: begin
                if (tmr_zero) state_d = CAPTURE;
            end
            CAPTURE: begin
`ifdef MEAS_ACCUM_EN
                if (iter_q == '1) begin
                    state_d = IDLE;
                end else begin
                    state_d  = CLEAR;
                    tmr_load = 1'b1;
                    tmr_val  = WIN_W'(CLEAR_CYC - 1);
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d  = IDLE;
            tmr_load = 1'b0;
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state they belong to.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q        <= IDLE;
            start_q        <= 1'b1;
            settle_q       <= '0;
            win_q          <= '0;
            adder_a_q      <= '0;
            adder_b_q      <= '0;
            chain_bypass_q <= 1'b0;
            ring_en_q      <= 1'b0;
            cnt_clear_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_q       <= '0;
`ifdef MEAS_ACCUM_EN
            acc_q          <= '0;
            iter_q         <= '0;
`endif
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            ring_en_q   <= (state_d == RUN);
            cnt_clear_q <= (state_d == CLEAR);
            busy_q      <= (state_d != IDLE);
            if (state_q == IDLE && state_d == CLEAR) begin
                adder_a_q      <= op_a;
                adder_b_q      <= op_b;
                chain_bypass_q <= bypass_sel;
                settle_q       <= settle_cycles;
                win_q          <= window_cycles;
                done_q         <= 1'b0;
`ifdef MEAS_ACCUM_EN
                acc_q          <= '0;
                iter_q         <= '0;
`endif
            end
            if (state_q == CAPTURE && !abort) begin
`ifdef MEAS_ACCUM_EN
                if (iter_q == '1) begin
                    result_q <= CNT_W'(acc_sum >> ACC_LOG2);
                    done_q   <= 1'b1;
                end else begin
                    acc_q  <= acc_sum;
                    iter_q <= iter_q + 1'b1;
                end
`else
                result_q <= ring_count;
                done_q   <= 1'b1;
`endif
            end
        end
    end

    assign adder_a      = adder_a_q;
    assign adder_b      = adder_b_q;
    assign chain_bypass = chain_bypass_q;
    assign ring_en      = ring_en_q;
    assign cnt_clear    = cnt_clear_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;

endmodule

// File: tb/tb_instr_adder_meas_ctrl.sv
// Self-checking bench for instr_adder_meas_ctrl (default build).
// A behavioural ring counter advances by a per-run rate while ring_en is high
// and clears on cnt_clear; expectations come from the phase-length arithmetic.
module tb_instr_adder_meas_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, bypass_sel;
    logic [7:0]  op_a, op_b;
    logic [15:0] window_cycles;
    logic [3:0]  settle_cycles;
    logic [23:0] ring_count = '0;
    logic [7:0]  adder_a, adder_b;
    logic        chain_bypass, ring_en, cnt_clear, busy, done;
    logic [23:0] result;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          rate     = 0;
    logic [23:0] exp_result;

    always #5 clk = ~clk;

    instr_adder_meas_ctrl dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .start         (start),
        .abort         (abort),
        .op_a          (op_a),
        .op_b          (op_b),
        .bypass_sel    (bypass_sel),
        .window_cycles (window_cycles),
        .settle_cycles (settle_cycles),
        .ring_count    (ring_count),
        .adder_a       (adder_a),
        .adder_b       (adder_b),
        .chain_bypass  (chain_bypass),
        .ring_en       (ring_en),
        .cnt_clear     (cnt_clear),
        .busy          (busy),
        .done          (done),
        .result        (result)
    );

    // Ring oscillator counter model.
    always @(posedge clk) begin
        if (cnt_clear)    ring_count <= '0;
        else if (ring_en) ring_count <= ring_count + 24'(rate);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One measurement; abort_at / glitch_at are cycle offsets after acceptance
    // (-1 disables). Cycle 0 is the first cycle spent in CLEAR.
    task automatic run_meas(input logic [7:0] a, input logic [7:0] b, input logic bp,
                            input int s, input int w, input int r,
                            input int abort_at, input int glitch_at);
        int c, lat, en_cnt, clr_cnt, done_at;
        bit aborted;
        rate = r;
        @(negedge clk);
        op_a = a; op_b = b; bypass_sel = bp;
        settle_cycles = 4'(s); window_cycles = 16'(w);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Late changes must not affect the run in progress.
        window_cycles = 16'($urandom); settle_cycles = 4'($urandom);
        op_a = 8'($urandom); op_b = 8'($urandom); bypass_sel = ~bp;
        check("done_drop", done, 0);
        check("busy_set", busy, 1);
        lat = 2 + s + w + 4 + 1;
        c = 0; en_cnt = 0; clr_cnt = 0; done_at = -1; aborted = 0;
        while (c <= lat + 10) begin
            if (done) begin done_at = c; break; end
            en_cnt  += int'(ring_en);
            clr_cnt += int'(cnt_clear);
            if (c == glitch_at)     start = 1'b1;
            if (c == glitch_at + 2) start = 1'b0;
            if (c == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_ring_en", ring_en, 0);
                check("abort_cnt_clear", cnt_clear, 0);
                check("abort_done", done, 0);
                check("abort_result", result, exp_result);
                aborted = 1;
                break;
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        if (!aborted) begin
            exp_result = 24'(w * r);
            check("latency", done_at, lat);
            check("ring_en_cycles", en_cnt, w);
            check("cnt_clear_cycles", clr_cnt, 2);
            check("result", result, exp_result);
            check("adder_a", adder_a, a);
            check("adder_b", adder_b, b);
            check("chain_bypass", chain_bypass, bp);
            repeat (4) @(negedge clk);
            check("done_hold", done, 1);
            check("idle_after_done", busy, 0);
            check("result_hold", result, exp_result);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; abort = 1'b0; bypass_sel = 1'b0;
        op_a = '0; op_b = '0; window_cycles = '0; settle_cycles = '0;
        exp_result = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ring_en", ring_en, 0);
        check("rst_cnt_clear", cnt_clear, 0);
        check("rst_result", result, 0);
        check("rst_adder_a", adder_a, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("start_held_through_reset", busy, 0);
        start = 1'b0;

        run_meas(8'h5A, 8'h3C, 1'b0, 3, 1000, 7, -1, -1);
        run_meas(8'hA5, 8'hC3, 1'b1, 0, 0, 9, -1, -1);

        for (int i = 0; i < 8; i++)
            run_meas(8'($urandom), 8'($urandom), 1'($urandom),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 300)),
                     int'($urandom_range(1, 50)), -1, -1);

        run_meas(8'h11, 8'h22, 1'b0, 10, 50, 3, 5, -1);   // abort in SETTLE
        run_meas(8'h33, 8'h44, 1'b1, 0, 100, 3, 30, -1);  // abort in RUN

        // Abort and request in the same idle cycle: request dropped.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("abort_start_still_idle", busy, 0);
        check("abort_start_ring_en", ring_en, 0);
        check("abort_start_result", result, exp_result);

        run_meas(8'h77, 8'h88, 1'b0, 2, 60, 5, -1, 10);   // start re-edge while busy
        run_meas(8'h99, 8'h0F, 1'b1, 1, 40, 11, -1, -1);  // re-request after done

        // Reset in the middle of RUN with start held high.
        rate = 2;
        @(negedge clk);
        settle_cycles = 4'd0; window_cycles = 16'd100; start = 1'b1;
        repeat (50) @(negedge clk);
        check("pre_reset_ring_en", ring_en, 1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_ring_en", ring_en, 0);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_done", done, 0);
        check("midrun_rst_result", result, 0);
        exp_result = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrun_rst_no_retrigger", busy, 0);
        start = 1'b0;

        run_meas(8'hF0, 8'h0F, 1'b0, 5, 77, 13, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
